// File: rtl/data_cache_pkg.sv
// Shared widths, access-mode encodings and FSM state type for the data cache.
package data_cache_pkg;

  localparam int unsigned WordW  = 32;
  localparam int unsigned QwordW = 128;

  localparam int unsigned ModeWord = 0;
  localparam int unsigned ModeHalf = 1;
  localparam int unsigned ModeByte = 2;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StWrite
  } state_e;

endpackage

// File: rtl/data_cache_store_merge.sv
// Merges right-aligned store data into an existing word according to access size.
module data_cache_store_merge
  import data_cache_pkg::*;
#(
  parameter int unsigned MODE_W = 2
) (
  input  logic [WordW-1:0]  old_word_i,
  input  logic [WordW-1:0]  wdata_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic [1:0]        addr_lo_i,
  output logic [WordW-1:0]  new_word_o
);

  always_comb begin
    new_word_o = old_word_i;
    if (mode_i == MODE_W'(ModeHalf)) begin
      if (addr_lo_i[1]) new_word_o[31:16] = wdata_i[15:0];
      else              new_word_o[15:0]  = wdata_i[15:0];
    end else if (mode_i == MODE_W'(ModeByte)) begin
      new_word_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
    end else begin
      // Word and the unused encoding both replace the full word.
      new_word_o = wdata_i;
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-word lines.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int unsigned LINES  = 16,
  parameter int unsigned MODE_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       cpuAddr,
  input  logic [31:0]       cpuWdata,
  input  logic [MODE_W-1:0] cpuMode,
  input  logic              cpuRead,
  input  logic              cpuWrite,
  output logic [31:0]       cpuRdata,
  output logic              cpuStall,
  output logic [31:0]       memAddr,
  output logic [31:0]       memWdata,
  output logic [MODE_W-1:0] memMode,
  output logic              memRead,
  output logic              memWrite,
  input  logic [127:0]      memQdata,
  input  logic              memReady
);

  localparam int unsigned IdxW = $clog2(LINES);
  localparam int unsigned TagW = 28 - IdxW;

  logic [IdxW-1:0]  idx;
  logic [TagW-1:0]  tag;
  logic [1:0]       off;
  logic             hit;
  logic [WordW-1:0] merged;

  logic [LINES-1:0] valid_q;
  logic [TagW-1:0]  tag_q  [LINES];
  logic [WordW-1:0] data_q [LINES][4];

  state_e state_q;
  logic   wr_done_q;
  logic   mem_read_q;
  logic   mem_write_q;

  assign off      = cpuAddr[3:2];
  assign idx      = cpuAddr[4 +: IdxW];
  assign tag      = cpuAddr[31 -: TagW];
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);
  assign cpuRdata = data_q[idx][off];
  assign memRead  = mem_read_q;
  assign memWrite = mem_write_q;

  data_cache_store_merge #(
    .MODE_W(MODE_W)
  ) u_merge (
    .old_word_i(data_q[idx][off]),
    .wdata_i   (cpuWdata),
    .mode_i    (cpuMode),
    .addr_lo_i (cpuAddr[1:0]),
    .new_word_o(merged)
  );

  // wr_done_q marks the single IDLE cycle in which a finished store retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      wr_done_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          wr_done_q <= 1'b0;
          if (!wr_done_q && cpuWrite) begin
            state_q     <= StWrite;
            mem_write_q <= 1'b1;
          end else if (!wr_done_q && cpuRead && !hit) begin
            state_q    <= StFill;
            mem_read_q <= 1'b1;
          end
        end
        StFill: begin
          if (memReady) begin
            state_q      <= StIdle;
            mem_read_q   <= 1'b0;
            valid_q[idx] <= 1'b1;
          end
        end
        StWrite: begin
          if (memReady) begin
            state_q     <= StIdle;
            mem_write_q <= 1'b0;
            wr_done_q   <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StFill && memReady) begin
      tag_q[idx] <= tag;
      for (int k = 0; k < 4; k++) data_q[idx][k] <= memQdata[32*k +: 32];
    end else if (state_q == StWrite && memReady && hit) begin
      data_q[idx][off] <= merged;
    end
  end

  always_comb begin
    cpuStall = 1'b0;
    memAddr  = '0;
    memWdata = '0;
    memMode  = '0;
    if (!rst) begin
      case (state_q)
        StIdle:  cpuStall = !wr_done_q && (cpuWrite || (cpuRead && !hit));
        StFill: begin
          cpuStall = 1'b1;
          memAddr  = {cpuAddr[31:4], 4'b0000};
        end
        StWrite: begin
          cpuStall = 1'b1;
          memAddr  = cpuAddr;
          memWdata = cpuWdata;
          memMode  = cpuMode;
        end
        default: cpuStall = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Randomized and directed bench for data_cache against a line/memory reference model.
module tb_data_cache;

  localparam int unsigned LINES = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  cpuAddr, cpuWdata, cpuRdata, memAddr, memWdata;
  logic [1:0]   cpuMode, memMode;
  logic         cpuRead, cpuWrite, cpuStall, memRead, memWrite, memReady;
  logic [127:0] memQdata;

  int total = 0;
  int bad   = 0;

  bit          m_valid [LINES];
  int unsigned m_tag   [LINES];
  logic [31:0] m_data  [LINES][4];
  logic [31:0] mem     [int unsigned];

  always #5 clk = ~clk;

  data_cache #(
    .LINES (LINES),
    .MODE_W(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cpuAddr (cpuAddr),
    .cpuWdata(cpuWdata),
    .cpuMode (cpuMode),
    .cpuRead (cpuRead),
    .cpuWrite(cpuWrite),
    .cpuRdata(cpuRdata),
    .cpuStall(cpuStall),
    .memAddr (memAddr),
    .memWdata(memWdata),
    .memMode (memMode),
    .memRead (memRead),
    .memWrite(memWrite),
    .memQdata(memQdata),
    .memReady(memReady)
  );

  function automatic int unsigned idx_of(input logic [31:0] a);
    return (a >> 4) % LINES;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] a);
    return a >> (4 + $clog2(LINES));
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
  endfunction

  function automatic logic [31:0] mem_rd(input int unsigned a);
    int unsigned key;
    key = a >> 2;
    if (!mem.exists(key)) mem[key] = $urandom;
    return mem[key];
  endfunction

  // Byte-lane view of a store: which lanes change and which source byte lands where.
  function automatic logic [31:0] apply_store(input logic [31:0] old, input logic [31:0] wd,
                                              input int unsigned a, input int mode);
    logic [31:0] r;
    int first, n;
    r = old;
    case (mode)
      1:       begin first = int'(a & 2); n = 2; end
      2:       begin first = int'(a & 3); n = 1; end
      default: begin first = 0;           n = 4; end
    endcase
    for (int b = 0; b < n; b++) r[(first + b) * 8 +: 8] = wd[b * 8 +: 8];
    return r;
  endfunction

  task automatic do_read(input logic [31:0] a, input int lat);
    int unsigned idx;
    bit          hit;
    logic [127:0] line;
    idx = idx_of(a);
    hit = model_hit(a);
    @(negedge clk);
    cpuAddr = a; cpuRead = 1'b1; cpuWrite = 1'b0;
    cpuMode = 2'($urandom); cpuWdata = $urandom;
    memQdata = {$urandom, $urandom, $urandom, $urandom};
    #1;
    if (!hit) begin
      total++;
      if ({cpuStall, memRead, memWrite} !== 3'b100) begin
        bad++; $display("FAIL miss_detect addr=%h got=%b want=100", a, {cpuStall, memRead, memWrite});
      end
      for (int w = 0; w < 4; w++) line[w * 32 +: 32] = mem_rd({a[31:4], 4'b0} + w * 4);
      for (int c = 1; c <= lat; c++) begin
        @(negedge clk);
        if (c == lat) begin memReady = 1'b1; memQdata = line; end
        #1;
        total++;
        if ({cpuStall, memRead, memWrite, memAddr} !== {3'b110, a[31:4], 4'b0}) begin
          bad++; $display("FAIL fill_strobe addr=%h got=%b/%h want=110/%h", a,
                          {cpuStall, memRead, memWrite}, memAddr, {a[31:4], 4'b0});
        end
      end
      @(negedge clk);
      memReady = 1'b0; memQdata = {$urandom, $urandom, $urandom, $urandom};
      #1;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag_of(a);
      for (int w = 0; w < 4; w++) m_data[idx][w] = line[w * 32 +: 32];
    end
    total++;
    if ({cpuStall, memRead, memWrite} !== 3'b000) begin
      bad++; $display("FAIL read_done addr=%h got=%b want=000", a, {cpuStall, memRead, memWrite});
    end
    total++;
    if (cpuRdata !== m_data[idx][a[3:2]]) begin
      bad++; $display("FAIL read_data addr=%h got=%h want=%h", a, cpuRdata, m_data[idx][a[3:2]]);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] mode,
                          input int lat, input bit both);
    int unsigned idx;
    bit          hit;
    idx = idx_of(a);
    hit = model_hit(a);
    @(negedge clk);
    cpuAddr = a; cpuWdata = wd; cpuMode = mode; cpuWrite = 1'b1; cpuRead = both;
    #1;
    total++;
    if ({cpuStall, memRead, memWrite} !== 3'b100) begin
      bad++; $display("FAIL store_start addr=%h got=%b want=100", a, {cpuStall, memRead, memWrite});
    end
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c == lat) memReady = 1'b1;
      #1;
      total++;
      if ({cpuStall, memRead, memWrite, memAddr, memWdata, memMode} !== {3'b101, a, wd, mode}) begin
        bad++; $display("FAIL store_strobe addr=%h got=%b/%h/%h/%0d want=101/%h/%h/%0d", a,
                        {cpuStall, memRead, memWrite}, memAddr, memWdata, memMode, a, wd, mode);
      end
    end
    @(negedge clk);
    memReady = 1'b0;
    #1;
    total++;
    if ({cpuStall, memRead, memWrite} !== 3'b000) begin
      bad++; $display("FAIL store_retire addr=%h got=%b want=000", a, {cpuStall, memRead, memWrite});
    end
    mem[a >> 2] = apply_store(mem_rd(a), wd, a, int'(mode));
    if (hit) m_data[idx][a[3:2]] = apply_store(m_data[idx][a[3:2]], wd, a, int'(mode));
  endtask

  task automatic do_idle(input bit pulse);
    @(negedge clk);
    cpuRead = 1'b0; cpuWrite = 1'b0; memReady = pulse;
    #1;
    total++;
    if ({cpuStall, memRead, memWrite} !== 3'b000) begin
      bad++; $display("FAIL idle got=%b want=000", {cpuStall, memRead, memWrite});
    end
    @(negedge clk);
    memReady = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; cpuAddr = 32'h1234_5678; cpuWdata = 32'hdead_beef; cpuMode = 2'd1;
    cpuRead = 1'b1; cpuWrite = 1'b0; memReady = 1'b0; memQdata = '0;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({cpuStall, memRead, memWrite, memAddr, memWdata, memMode} !== '0) begin
      bad++; $display("FAIL reset_read got=%b/%h/%h/%0d want=all zero",
                      {cpuStall, memRead, memWrite}, memAddr, memWdata, memMode);
    end
    cpuWrite = 1'b1;
    #1;
    total++;
    if ({cpuStall, memRead, memWrite, memAddr, memWdata, memMode} !== '0) begin
      bad++; $display("FAIL reset_write got=%b/%h/%h/%0d want=all zero",
                      {cpuStall, memRead, memWrite}, memAddr, memWdata, memMode);
    end
    for (int i = 0; i < int'(LINES); i++) m_valid[i] = 1'b0;
    @(negedge clk);
    rst = 1'b0; cpuRead = 1'b0; cpuWrite = 1'b0;
    do_idle(1'b0);
  endtask

  task automatic test_directed();
    do_read(32'h100, 3);
    do_read(32'h10C, 1);
    do_write(32'h101, 32'h0000_00AB, 2'd2, 2, 1'b0);
    do_read(32'h100, 1);
    do_write(32'h200, $urandom, 2'd0, 1, 1'b0);
    do_read(32'h200, 2);
    do_read(32'h000, 1);
    do_read(32'h100, 1);
    do_read(32'h000, 1);
    do_idle(1'b1);
    do_read(32'h004, 1);
  endtask

  task automatic test_reset_in_fill();
    do_read(32'h040, 1);
    @(negedge clk);
    cpuAddr = 32'hABC50; cpuRead = 1'b1; cpuWrite = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (memRead !== 1'b1) begin
      bad++; $display("FAIL rif_fill_start got=%b want=1", memRead);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({cpuStall, memRead, memWrite} !== 3'b000) begin
      bad++; $display("FAIL rif_abort got=%b want=000", {cpuStall, memRead, memWrite});
    end
    for (int i = 0; i < int'(LINES); i++) m_valid[i] = 1'b0;
    @(negedge clk);
    rst = 1'b0; cpuRead = 1'b0;
    @(negedge clk);
    memReady = 1'b1; memQdata = {4{32'hBAD0_BAD0}};
    #1;
    total++;
    if ({cpuStall, memRead, memWrite} !== 3'b000) begin
      bad++; $display("FAIL rif_late_ready got=%b want=000", {cpuStall, memRead, memWrite});
    end
    @(negedge clk);
    memReady = 1'b0;
    do_read(32'h040, 2);
    do_read(32'hABC50, 2);
  endtask

  task automatic test_back_to_back();
    do_read(32'h380, 2);
    for (int i = 0; i < 4; i++) do_read(32'h380 + i * 4, 1);
    do_write(32'h386, 32'h0000_5A5A, 2'd1, 1, 1'b0);
    do_read(32'h384, 1);
    do_write(32'h388, 32'hCAFE_F00D, 2'd3, 1, 1'b1);
    do_read(32'h388, 1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [1:0]  mode;
    int op;
    for (int n = 0; n < 300; n++) begin
      a = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 3) << 4) | ($urandom & 15);
      mode = 2'($urandom);
      if (mode == 2'd0 || mode == 2'd3) a = a & ~32'd3;
      else if (mode == 2'd1) a = a & ~32'd1;
      op = $urandom_range(0, 7);
      if (op < 4)       do_read(a, $urandom_range(1, 4));
      else if (op < 6)  do_write(a, $urandom, mode, $urandom_range(1, 4), 1'b0);
      else if (op == 6) do_write(a, $urandom, mode, $urandom_range(1, 4), 1'b1);
      else              do_idle(1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_in_fill();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter LINES, default 16, number of direct-mapped lines (power of two, >= 2).
REQ-002 Parameter MODE_W, default 2, width of the access-mode field.
REQ-003 clk  in  1  system clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 cpuAddr  in  32  byte address from the MEM stage.
REQ-006 cpuWdata  in  32  store data, right-aligned (low bits for byte and half stores).
REQ-007 cpuMode  in  MODE_W  access size: 0 = word, 1 = half, 2 = byte.
REQ-008 cpuRead / cpuWrite  in  1  load / store request; held stable while cpuStall is 1.
REQ-009 cpuRdata  out  32  aligned word containing the addressed data.
REQ-010 cpuStall  out  1  freeze request to the pipeline.
REQ-011 memAddr  out  32  address to data memory.
REQ-012 memWdata  out  32  store data.
REQ-013 memMode  out  MODE_W  store size.
REQ-014 memRead / memWrite  out  1  line-fill / store strobes.
REQ-015 memQdata  in  128  fill line; word k occupies bits [32k+31:32k].
REQ-016 memReady  in  1  one-cycle completion pulse for the current memRead or memWrite.

Function
REQ-017 Address split: offset = cpuAddr[3:2]; index = cpuAddr[3+log2(LINES):4]; tag = the remaining upper bits.
REQ-018 Per line: valid bit, tag, 4x32-bit data.
REQ-019 FSM has three states: IDLE, FILL, WRITE.
REQ-020 Read hit in IDLE: cpuRdata = cached word, combinational in the same cycle; cpuStall = 0; no memory strobe.
REQ-021 Read miss in IDLE: cpuStall = 1 combinationally; next state FILL.
REQ-022 FILL: memRead = 1, memAddr = {cpuAddr[31:4], 4'b0}, cpuStall = 1.
REQ-023 FILL exit: on memReady = 1, write memQdata, tag and valid = 1 into the line; go to IDLE.
REQ-024 After a fill, the held request hits in the next IDLE cycle; miss penalty = memory latency + 1 cycle.
REQ-025 Write in IDLE (hit or miss): cpuStall = 1; next state WRITE. Policy is write-through, no write-allocate.
REQ-026 WRITE: memWrite = 1; memAddr = cpuAddr; memWdata = cpuWdata; memMode = cpuMode; cpuStall = 1.
REQ-027 WRITE exit: on memReady = 1, go to IDLE and drop cpuStall in that IDLE cycle, so the store retires; a valid tag match at that edge updates the cached lanes.
REQ-028 Store lanes:
  - word: all 4 bytes.
  - half: bytes {addr[1],0} and {addr[1],1}, taking cpuWdata[15:0].
  - byte: byte addr[1:0], taking cpuWdata[7:0].
  - A store miss leaves the cache unchanged.
REQ-029 cpuMode = 3 is treated as word.
REQ-030 cpuRead and cpuWrite both 1: the write is serviced and the read is ignored.
REQ-031 memReady while in IDLE is ignored.
REQ-032 memRead and memWrite are never 1 together.
REQ-033 Neither cpuRead nor cpuWrite asserted: stay in IDLE with cpuStall = 0.
REQ-034 Index wrap-around: addresses differing only in tag map to the same line; a fill replaces the old line unconditionally.
REQ-035 cpuRdata is don't-care when cpuRead = 0, and holds the stale-line value while stalled.

Reset
REQ-036 rst = 1 asynchronously forces: state IDLE, all valid bits 0, memRead = 0, memWrite = 0.
REQ-037 During reset, cpuStall = 0, memAddr = 0, memWdata = 0, memMode = 0.
REQ-038 Data and tag arrays are not reset.
REQ-039 Reset during FILL or WRITE aborts the transfer; a memReady arriving after reset release is ignored.

Structure
REQ-040 Mode encodings and the word/qword width macros live in the shared ISA header.
REQ-041 One sub-module, data_cache_store_merge: combinational lane merge of (old word, cpuWdata, cpuMode, addr[1:0]) into the new word.
REQ-042 The FSM and arrays stay in data_cache.

Verification
REQ-043 Cold read of 0x100 with memReady 3 cycles after memRead: cpuStall is high 4 cycles; memAddr = 0x100; then cpuRdata = memQdata word 0.
REQ-044 Repeat read of 0x10C: cpuStall = 0 and the same-cycle cpuRdata equals memQdata bits [127:96], with no memRead.
REQ-045 Byte store 0xAB to 0x101 (hit): memWrite is held until memReady; a later read of 0x100 returns the old word with byte 1 = 0xAB.
REQ-046 Store to uncached 0x200: memWrite pulse occurs, then a read of 0x200 misses and issues a fill.
REQ-047 Conflict at LINES = 16: read 0x000, then read 0x100 (same index, different tag) -> the second read misses; reading 0x000 again misses again.
REQ-048 rst asserted in the second cycle of a FILL: memRead drops immediately, all lines read as invalid, and a late memReady causes no array write.
